// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance sequencer.
package tlb_maint_ctrl_pkg;

  localparam int unsigned ASID_W      = 10;
  localparam int unsigned VPPN_W      = 19;
  localparam int unsigned PS_W        = 6;
  localparam int unsigned OP_W        = 5;
  localparam int unsigned VPPN_4M_LSB = 10;

  localparam logic [PS_W-1:0] PS_4M      = PS_W'(21);
  localparam logic [PS_W-1:0] PS_4K      = PS_W'(12);
  localparam logic [OP_W-1:0] INV_OP_MAX = OP_W'(6);

  // ent_wsel encodings
  localparam logic WSEL_CSR   = 1'b0;
  localparam logic WSEL_CLR_E = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SRCH_SCAN = 3'd1,
    ST_RD        = 3'd2,
    ST_WR        = 3'd3,
    ST_FILL      = 3'd4,
    ST_INV_SCAN  = 3'd5
  } tlb_state_e;

  typedef enum logic [2:0] {
    INV_ALL_0      = 3'd0,
    INV_ALL_1      = 3'd1,
    INV_G          = 3'd2,
    INV_NG         = 3'd3,
    INV_NG_ASID    = 3'd4,
    INV_NG_ASID_VA = 3'd5,
    INV_GA_VA      = 3'd6
  } inv_op_e;

  typedef struct packed {
    logic [ASID_W-1:0] asid;
    logic [VPPN_W-1:0] vppn;
  } tlb_key_t;

endpackage

// File: rtl/tlb_entry_match.sv
// Combinational compare of one TLB entry against a search/invalidate key.
module tlb_entry_match
  import tlb_maint_ctrl_pkg::*;
(
  input  tlb_key_t          key,
  input  inv_op_e           op,
  input  logic              ent_e,
  input  logic              ent_g,
  input  logic [ASID_W-1:0] ent_asid,
  input  logic [VPPN_W-1:0] ent_vppn,
  input  logic [PS_W-1:0]   ent_ps,
  output logic              srch_hit_c,
  output logic              inv_hit_c
);

  logic va_match;
  logic asid_match;

  // Page-size-aware VPPN compare: 4M pages ignore the low VPPN bits
  always_comb begin
    if (ent_ps == PS_4M) begin
      va_match = (ent_vppn[VPPN_W-1:VPPN_4M_LSB] == key.vppn[VPPN_W-1:VPPN_4M_LSB]);
    end else begin
      va_match = (ent_vppn == key.vppn);
    end
  end

  assign asid_match = (ent_asid == key.asid);
  assign srch_hit_c = ent_e & va_match & (ent_g | asid_match);

  // INVTLB entry selection; the valid bit plays no part
  always_comb begin
    inv_hit_c = 1'b0;
    case (op)
      INV_ALL_0, INV_ALL_1: inv_hit_c = 1'b1;
      INV_G:                inv_hit_c = ent_g;
      INV_NG:               inv_hit_c = ~ent_g;
      INV_NG_ASID:          inv_hit_c = ~ent_g & asid_match;
      INV_NG_ASID_VA:       inv_hit_c = ~ent_g & asid_match & va_match;
      INV_GA_VA:            inv_hit_c = (ent_g | asid_match) & va_match;
      default:              inv_hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the entry array.
// Build option: TLB_FILL_LFSR_EN selects an 8-bit LFSR as the TLBFILL index source.
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned TLB_NUM = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tlbsrch_valid,
  input  logic              tlbrd_valid,
  input  logic              tlbwr_valid,
  input  logic              tlbfill_valid,
  input  logic              invtlb_valid,
  input  logic [OP_W-1:0]   invtlb_op,
  input  logic [ASID_W-1:0] invtlb_asid,
  input  logic [VPPN_W-1:0] invtlb_va,
  output logic              tlbsrch_ready,
  output logic              tlbrd_ready,
  output logic              tlbwr_ready,
  output logic              tlbfill_ready,
  output logic              invtlb_ready,
  output logic              inv_op_err,
  input  logic [IDX_W-1:0]  csr_tlbidx_index,
  input  logic [ASID_W-1:0] csr_asid,
  input  logic [VPPN_W-1:0] csr_tlbehi_vppn,
  output logic [IDX_W-1:0]  ent_addr,
  input  logic              ent_e,
  input  logic              ent_g,
  input  logic [ASID_W-1:0] ent_asid,
  input  logic [VPPN_W-1:0] ent_vppn,
  input  logic [PS_W-1:0]   ent_ps,
  output logic              ent_we,
  output logic              ent_wsel,
  output logic              csr_srch_we,
  output logic              csr_srch_hit,
  output logic [IDX_W-1:0]  csr_srch_idx,
  output logic              csr_rd_we,
  output logic              tlb_busy,
  output logic              tlb_changed
);

  tlb_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0] fill_idx;
  logic [OP_W-1:0]  op_q, op_d;
  tlb_key_t         inv_key_q, inv_key_d;
  tlb_key_t         match_key;
  logic             chg_q, chg_d;
  logic             scan_last;
  logic             srch_hit;
  logic             inv_hit;

`ifdef TLB_FILL_LFSR_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 8'h01;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign fill_idx = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] fill_cnt_q;

  // Free-running fill index, wraps at TLB_NUM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fill_cnt_q <= '0;
    else       fill_cnt_q <= fill_cnt_q + IDX_W'(1);
  end

  assign fill_idx = fill_cnt_q;
`endif

  assign scan_last = (cnt_q == IDX_W'(TLB_NUM - 1));
  assign tlb_busy  = (state_q != ST_IDLE);

  // TLBSRCH keys from live CSRs; INVTLB uses operands captured at accept
  always_comb begin
    if (state_q == ST_SRCH_SCAN) begin
      match_key.asid = csr_asid;
      match_key.vppn = csr_tlbehi_vppn;
    end else begin
      match_key = inv_key_q;
    end
  end

  tlb_entry_match u_match (
    .key        (match_key),
    .op         (inv_op_e'(op_q[2:0])),
    .ent_e      (ent_e),
    .ent_g      (ent_g),
    .ent_asid   (ent_asid),
    .ent_vppn   (ent_vppn),
    .ent_ps     (ent_ps),
    .srch_hit_c (srch_hit),
    .inv_hit_c  (inv_hit)
  );

  // State and operand registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fill_q    <= '0;
      op_q      <= '0;
      inv_key_q <= '0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      op_q      <= op_d;
      inv_key_q <= inv_key_d;
      chg_q     <= chg_d;
    end
  end

  // Next-state, array control and CSR strobes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_d        = fill_q;
    op_d          = op_q;
    inv_key_d     = inv_key_q;
    chg_d         = chg_q;
    ent_addr      = '0;
    ent_we        = 1'b0;
    ent_wsel      = WSEL_CSR;
    csr_srch_we   = 1'b0;
    csr_srch_hit  = 1'b0;
    csr_srch_idx  = '0;
    csr_rd_we     = 1'b0;
    tlbsrch_ready = 1'b0;
    tlbrd_ready   = 1'b0;
    tlbwr_ready   = 1'b0;
    tlbfill_ready = 1'b0;
    invtlb_ready  = 1'b0;
    inv_op_err    = 1'b0;
    tlb_changed   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        chg_d = 1'b0;
        if (tlbsrch_valid) begin
          state_d = ST_SRCH_SCAN;
        end else if (tlbrd_valid) begin
          state_d = ST_RD;
        end else if (tlbwr_valid) begin
          state_d = ST_WR;
        end else if (tlbfill_valid) begin
          state_d = ST_FILL;
          fill_d  = fill_idx;
        end else if (invtlb_valid) begin
          state_d        = ST_INV_SCAN;
          op_d           = invtlb_op;
          inv_key_d.asid = invtlb_asid;
          inv_key_d.vppn = invtlb_va;
        end
      end

      ST_SRCH_SCAN: begin
        ent_addr = cnt_q;
        if (srch_hit || scan_last) begin
          csr_srch_we   = 1'b1;
          csr_srch_hit  = srch_hit;
          csr_srch_idx  = srch_hit ? cnt_q : '0;
          tlbsrch_ready = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end

      ST_RD: begin
        ent_addr    = csr_tlbidx_index;
        csr_rd_we   = 1'b1;
        tlbrd_ready = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_WR: begin
        ent_addr    = csr_tlbidx_index;
        ent_we      = 1'b1;
        ent_wsel    = WSEL_CSR;
        tlbwr_ready = 1'b1;
        tlb_changed = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_FILL: begin
        ent_addr      = fill_q;
        ent_we        = 1'b1;
        ent_wsel      = WSEL_CSR;
        tlbfill_ready = 1'b1;
        tlb_changed   = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_INV_SCAN: begin
        if (op_q > INV_OP_MAX) begin
          invtlb_ready = 1'b1;
          inv_op_err   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          ent_addr = cnt_q;
          if (inv_hit) begin
            ent_we   = 1'b1;
            ent_wsel = WSEL_CLR_E;
            chg_d    = 1'b1;
          end
          if (scan_last) begin
            invtlb_ready = 1'b1;
            tlb_changed  = chg_q | inv_hit;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl with a behavioural TLB array and reference model.
module tb_tlb_maint_ctrl;

  localparam int unsigned TLB_NUM = 16;
  localparam int unsigned IDX_W   = 4;

  logic        clk, rstn;
  logic        tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_va;
  logic        tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready, inv_op_err;
  logic [3:0]  csr_tlbidx_index;
  logic [9:0]  csr_asid;
  logic [18:0] csr_tlbehi_vppn;
  logic [3:0]  ent_addr;
  logic        ent_e, ent_g;
  logic [9:0]  ent_asid;
  logic [18:0] ent_vppn;
  logic [5:0]  ent_ps;
  logic        ent_we, ent_wsel, csr_srch_we, csr_srch_hit, csr_rd_we, tlb_busy, tlb_changed;
  logic [3:0]  csr_srch_idx;

  // behavioural entry array
  logic        m_e    [TLB_NUM];
  logic        m_g    [TLB_NUM];
  logic [9:0]  m_asid [TLB_NUM];
  logic [18:0] m_vppn [TLB_NUM];
  logic [5:0]  m_ps   [TLB_NUM];

  typedef struct {
    int          kind;   // 0 srch, 1 rd, 2 wr, 3 fill, 4 inv
    int          lat;
    int          acc;
    logic        hit;
    logic [3:0]  idx;
    logic [3:0]  addr;
    logic        err;
    logic        chg;
    logic        we;
    logic [15:0] emask;
    logic [18:0] wvppn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   issued = 0;
  int   done_cnt = 0;
  int   cyc;

  tlb_maint_ctrl #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rstn(rstn),
    .tlbsrch_valid(tlbsrch_valid), .tlbrd_valid(tlbrd_valid), .tlbwr_valid(tlbwr_valid),
    .tlbfill_valid(tlbfill_valid), .invtlb_valid(invtlb_valid),
    .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va),
    .tlbsrch_ready(tlbsrch_ready), .tlbrd_ready(tlbrd_ready), .tlbwr_ready(tlbwr_ready),
    .tlbfill_ready(tlbfill_ready), .invtlb_ready(invtlb_ready), .inv_op_err(inv_op_err),
    .csr_tlbidx_index(csr_tlbidx_index), .csr_asid(csr_asid), .csr_tlbehi_vppn(csr_tlbehi_vppn),
    .ent_addr(ent_addr), .ent_e(ent_e), .ent_g(ent_g), .ent_asid(ent_asid),
    .ent_vppn(ent_vppn), .ent_ps(ent_ps), .ent_we(ent_we), .ent_wsel(ent_wsel),
    .csr_srch_we(csr_srch_we), .csr_srch_hit(csr_srch_hit), .csr_srch_idx(csr_srch_idx),
    .csr_rd_we(csr_rd_we), .tlb_busy(tlb_busy), .tlb_changed(tlb_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since reset release; equals the free-running fill counter value
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  assign ent_e    = m_e[ent_addr];
  assign ent_g    = m_g[ent_addr];
  assign ent_asid = m_asid[ent_addr];
  assign ent_vppn = m_vppn[ent_addr];
  assign ent_ps   = m_ps[ent_addr];

  // array write port: CSR write or E clear
  always @(posedge clk) begin
    if (ent_we) begin
      if (ent_wsel) begin
        m_e[ent_addr] <= 1'b0;
      end else begin
        m_e[ent_addr]    <= 1'b1;
        m_g[ent_addr]    <= 1'b0;
        m_asid[ent_addr] <= csr_asid;
        m_vppn[ent_addr] <= csr_tlbehi_vppn;
        m_ps[ent_addr]   <= 6'd12;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic preload(input int i, input logic e, input logic g, input logic [9:0] a,
                         input logic [18:0] v, input logic [5:0] ps);
    m_e[i] <= e; m_g[i] <= g; m_asid[i] <= a; m_vppn[i] <= v; m_ps[i] <= ps;
    #1;
  endtask

  function automatic bit va_hit(input int i, input logic [18:0] v);
    if (m_ps[i] == 6'd21) return (m_vppn[i] >> 10) == (v >> 10);
    return m_vppn[i] == v;
  endfunction

  function automatic bit inv_rule(input int op, input int i, input logic [9:0] ka, input logic [18:0] kv);
    bit am, vm;
    am = (m_asid[i] == ka);
    vm = va_hit(i, kv);
    case (op)
      0, 1:    return 1'b1;
      2:       return m_g[i];
      3:       return !m_g[i];
      4:       return !m_g[i] && am;
      5:       return !m_g[i] && am && vm;
      6:       return (m_g[i] || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  // reference model: expected result of one operation from the current array and CSRs
  function automatic exp_t predict(input int kind, input int op, input logic [9:0] ka, input logic [18:0] kv);
    exp_t x;
    x.kind = kind; x.lat = 1; x.acc = 0; x.hit = 1'b0; x.idx = 4'd0; x.addr = 4'd0;
    x.err = 1'b0; x.chg = 1'b0; x.we = 1'b0; x.wvppn = csr_tlbehi_vppn;
    for (int i = 0; i < 16; i++) x.emask[i] = m_e[i];
    case (kind)
      0: begin
        x.lat = 16; x.addr = 4'd15;
        for (int i = 15; i >= 0; i--) begin
          if (m_e[i] && va_hit(i, csr_tlbehi_vppn) && (m_g[i] || m_asid[i] == csr_asid)) begin
            x.hit = 1'b1; x.idx = 4'(i); x.addr = 4'(i); x.lat = i + 1;
          end
        end
      end
      1: x.addr = csr_tlbidx_index;
      2: begin
        x.addr = csr_tlbidx_index; x.emask[csr_tlbidx_index] = 1'b1; x.chg = 1'b1; x.we = 1'b1;
      end
      3: begin
        x.addr = 4'(cyc % 16); x.emask[cyc % 16] = 1'b1; x.chg = 1'b1; x.we = 1'b1;
      end
      default: begin
        if (op > 6) begin
          x.err = 1'b1;
        end else begin
          x.lat = 16; x.addr = 4'd15;
          for (int i = 0; i < 16; i++) begin
            if (inv_rule(op, i, ka, kv)) begin
              x.emask[i] = 1'b0; x.chg = 1'b1;
              if (i == 15) x.we = 1'b1;
            end
          end
        end
      end
    endcase
    return x;
  endfunction

  // issue one request pulse, push its expectation, wait (bounded) for completion
  task automatic issue(input logic [4:0] vm, input logic [4:0] op, input logic [9:0] ka,
                       input logic [18:0] kv, input bit stray);
    exp_t x;
    int kind;
    kind = 4;
    for (int b = 4; b >= 0; b--) if (vm[b]) kind = b;
    x = predict(kind, int'(op), ka, kv);
    x.acc = cyc;
    sb.push_back(x);
    issued++;
    {invtlb_valid, tlbfill_valid, tlbwr_valid, tlbrd_valid, tlbsrch_valid} = vm;
    invtlb_op = op; invtlb_asid = ka; invtlb_va = kv;
    @(negedge clk);
    {invtlb_valid, tlbfill_valid, tlbwr_valid, tlbrd_valid, tlbsrch_valid} = 5'b0;
    invtlb_op = 5'($urandom); invtlb_asid = 10'($urandom); invtlb_va = 19'($urandom);
    if (stray && x.lat > 6) begin
      repeat (3) @(negedge clk);
      tlbrd_valid = 1'b1;
      @(negedge clk);
      tlbrd_valid = 1'b0;
    end
    for (int k = 0; k < 64 && done_cnt < issued; k++) @(negedge clk);
    if (done_cnt < issued) begin
      chk("timeout_done", 32'(done_cnt), 32'(issued));
      sb.delete();
      done_cnt = issued;
    end
  endtask

  // monitor: pop and compare whenever a ready pulse is presented
  initial begin : monitor
    exp_t        x;
    logic [4:0]  rdy;
    logic [15:0] em;
    forever begin
      @(negedge clk);
      rdy = {invtlb_ready, tlbfill_ready, tlbwr_ready, tlbrd_ready, tlbsrch_ready};
      if (rstn && rdy != 5'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(rdy), 32'(0));
        end else begin
          x = sb.pop_front();
          chk("ready_kind", 32'(rdy), 32'(1) << x.kind);
          chk("latency", 32'(cyc - x.acc), 32'(x.lat));
          chk("busy_at_ready", 32'(tlb_busy), 32'(1));
          chk("srch_we", 32'(csr_srch_we), 32'(x.kind == 0));
          chk("srch_hit", 32'(csr_srch_hit), 32'(x.hit));
          if (x.hit) chk("srch_idx", 32'(csr_srch_idx), 32'(x.idx));
          chk("rd_we", 32'(csr_rd_we), 32'(x.kind == 1));
          chk("op_err", 32'(inv_op_err), 32'(x.err));
          chk("changed", 32'(tlb_changed), 32'(x.chg));
          chk("ent_we", 32'(ent_we), 32'(x.we));
          if (x.we) chk("ent_wsel", 32'(ent_wsel), 32'(x.kind == 4));
          if (!x.err) chk("ent_addr", 32'(ent_addr), 32'(x.addr));
          @(negedge clk);
          chk("busy_after", 32'(tlb_busy), 32'(0));
          for (int i = 0; i < 16; i++) em[i] = m_e[i];
          chk("emask", 32'(em), 32'(x.emask));
          if (x.kind == 2 || x.kind == 3) chk("wr_vppn", 32'(m_vppn[x.addr]), 32'(x.wvppn));
          done_cnt++;
        end
      end
    end
  end

  function automatic logic [9:0] pick_asid();
    return 10'($urandom_range(3, 5));
  endfunction

  function automatic logic [18:0] pick_va();
    case ($urandom_range(0, 3))
      0:       return 19'h12345;
      1:       return 19'h12C00;
      2:       return 19'h12DFF;
      default: return 19'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [4:0]  vm;
    logic [15:0] em;
    rstn = 1'b0;
    {invtlb_valid, tlbfill_valid, tlbwr_valid, tlbrd_valid, tlbsrch_valid} = 5'b0;
    invtlb_op = '0; invtlb_asid = '0; invtlb_va = '0;
    csr_tlbidx_index = '0; csr_asid = '0; csr_tlbehi_vppn = '0;
    for (int i = 0; i < 16; i++) begin
      m_e[i] <= 1'b0; m_g[i] <= 1'b0; m_asid[i] <= '0; m_vppn[i] <= '0; m_ps[i] <= 6'd12;
    end
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", 32'(tlb_busy), 32'(0));
    chk("rst_ent_we", 32'(ent_we), 32'(0));
    chk("rst_readies", 32'({invtlb_ready, tlbfill_ready, tlbwr_ready, tlbrd_ready, tlbsrch_ready}), 32'(0));
    chk("rst_changed", 32'(tlb_changed), 32'(0));
    chk("rst_srch_we", 32'(csr_srch_we), 32'(0));
    chk("rst_rd_we", 32'(csr_rd_we), 32'(0));
    chk("rst_op_err", 32'(inv_op_err), 32'(0));
    chk("rst_ent_addr", 32'(ent_addr), 32'(0));
    rstn = 1'b1;

    // TLBFILL accepted 37 cycles after reset: index 37 mod 16
    csr_tlbehi_vppn = 19'h0BEEF;
    while (cyc < 37) @(negedge clk);
    issue(5'b01000, 5'd0, 10'd0, 19'd0, 1'b0);

    // directed search / invalidate cases
    preload(5, 1'b1, 1'b0, 10'h3, 19'h12345, 6'd12);
    preload(2, 1'b1, 1'b1, 10'h7, 19'h12C00, 6'd21);
    csr_asid = 10'd3; csr_tlbehi_vppn = 19'h12345;
    issue(5'b00001, 5'd0, 10'd0, 19'd0, 1'b1);
    csr_asid = 10'd4;
    issue(5'b00001, 5'd0, 10'd0, 19'd0, 1'b1);
    csr_tlbehi_vppn = 19'h12DFF;
    issue(5'b00001, 5'd0, 10'd0, 19'd0, 1'b0);
    preload(7, 1'b1, 1'b1, 10'h3, 19'h12345, 6'd12);
    issue(5'b10000, 5'd5, 10'h3, 19'h12345, 1'b1);
    issue(5'b10000, 5'd9, 10'h3, 19'h12345, 1'b0);
    csr_tlbidx_index = 4'd9; csr_tlbehi_vppn = 19'h2AAAA;
    issue(5'b00010, 5'd0, 10'd0, 19'd0, 1'b0);
    issue(5'b00100, 5'd0, 10'd0, 19'd0, 1'b0);
    issue(5'b11110, 5'd0, 10'd0, 19'd0, 1'b0);
    issue(5'b11000, 5'd0, 10'd0, 19'd0, 1'b0);

    // randomized operations
    for (int n = 0; n < 45; n++) begin
      if ($urandom_range(0, 2) != 0)
        preload($urandom_range(0, 15), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                pick_asid(), pick_va(), ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12);
      csr_asid = pick_asid();
      csr_tlbehi_vppn = pick_va();
      csr_tlbidx_index = 4'($urandom_range(0, 15));
      vm = 5'(32'(1) << $urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) vm = 5'($urandom_range(1, 31));
      issue(vm, 5'($urandom_range(0, 9)), pick_asid(), pick_va(), (n % 3) == 0);
    end

    // reset during INV_SCAN at index 3 aborts the scan
    for (int i = 0; i < 16; i++) m_e[i] <= 1'b1;
    #1;
    invtlb_valid = 1'b1; invtlb_op = 5'd0;
    @(negedge clk);
    invtlb_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idx", 32'(ent_addr), 32'(3));
    chk("abort_we_pre", 32'(ent_we), 32'(1));
    rstn = 1'b0;
    #1;
    chk("abort_busy", 32'(tlb_busy), 32'(0));
    chk("abort_we", 32'(ent_we), 32'(0));
    chk("abort_ready", 32'(invtlb_ready), 32'(0));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) em[i] = m_e[i];
    chk("abort_emask", 32'(em), 32'(16'hFFF8));
    rstn = 1'b1;
    @(negedge clk);

    // recovery after abort
    csr_asid = 10'd3; csr_tlbehi_vppn = 19'h12345;
    issue(5'b00001, 5'd0, 10'd0, 19'd0, 1'b0);
    issue(5'b10000, 5'd2, 10'd0, 19'd0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
Sequences TLB maintenance operations (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) requested by the privileged-instruction EX unit onto the single-read/single-write TLB entry array.
Latches each one-cycle request, scans or addresses the array, and drives CSR update strobes. Returns a one-cycle ready pulse per operation and signals L0 ITLB/DTLB flush on any array modification.

Parameters:
TLB_NUM, 16, number of TLB entries (power of two)
IDX_W, 4, log2(TLB_NUM)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
tlbsrch_valid  in  1  TLBSRCH request, one-cycle pulse
tlbrd_valid  in  1  TLBRD request
tlbwr_valid  in  1  TLBWR request
tlbfill_valid  in  1  TLBFILL request
invtlb_valid  in  1  INVTLB request
invtlb_op  in  5  INVTLB op code, sampled with invtlb_valid
invtlb_asid  in  10  ASID operand, sampled with invtlb_valid
invtlb_va  in  19  VPPN operand, sampled with invtlb_valid
tlbsrch_ready / tlbrd_ready / tlbwr_ready / tlbfill_ready / invtlb_ready  out  1 each  completion pulses
inv_op_err  out  1  pulse with invtlb_ready when op > 6
csr_tlbidx_index  in  IDX_W  TLBIDX.Index
csr_asid  in  10  ASID.ASID
csr_tlbehi_vppn  in  19  TLBEHI.VPPN
ent_addr  out  IDX_W  array address (read is combinational; write uses same address)
ent_e / ent_g  in  1 each  entry valid / global bit at ent_addr
ent_asid  in  10  entry ASID
ent_vppn  in  19  entry VPPN
ent_ps  in  6  entry page size
ent_we  out  1  array write strobe
ent_wsel  out  1  0 = write fields from CSRs, 1 = clear E only
csr_srch_we  out  1  TLBSRCH result write strobe
csr_srch_hit  out  1  1 = hit (clear NE, write index); 0 = set NE
csr_srch_idx  out  IDX_W  hit index
csr_rd_we  out  1  TLBRD strobe; CSRs capture array data at ent_addr
tlb_busy  out  1  state != IDLE
tlb_changed  out  1  one-cycle pulse, last cycle of any op that asserted ent_we

Behaviour:
- Reset: state IDLE, all outputs 0, fill index 0. Reset mid-operation aborts it with no further writes and no ready pulse.
- IDLE: sample valids. Priority srch > rd > wr > fill > inv. Latch operands and scan counter = 0. Valids outside IDLE are ignored.
- Entry match (per cycle, combinational):
  - VA match compares vppn[18:10] only when ent_ps == 21, else all 19 bits.
  - ASID match = (ent_asid == key_asid).
- SRCH_SCAN:
  - Key = csr_tlbehi_vppn/csr_asid. An entry hits when e & VA match & (g | ASID match).
  - ent_addr = counter. First (lowest-index) hit ends the op in that cycle with csr_srch_we=1, hit=1, idx=counter, tlbsrch_ready=1.
  - No hit by index TLB_NUM-1 ends the op there with hit=0.
  - Latency: counter+1 cycles after accept.
- RD: one cycle. ent_addr = csr_tlbidx_index, csr_rd_we=1, tlbrd_ready=1.
- WR: one cycle. ent_addr = csr_tlbidx_index, ent_we=1, ent_wsel=0, tlbwr_ready=1, tlb_changed=1.
- FILL: one cycle. ent_addr = fill index latched at accept; ent_we=1, ent_wsel=0, tlbfill_ready=1, tlb_changed=1.
  - Fill index: free-running counter, +1 every clk, wraps mod TLB_NUM.
- INV_SCAN:
  - Ops > 6: no scan; one cycle with invtlb_ready=1, inv_op_err=1, no writes.
  - Otherwise scan counter 0..TLB_NUM-1, one entry per cycle. ent_we=1 with ent_wsel=1 when the entry matches op:
    - op 0, 1: all entries
    - op 2: g=1
    - op 3: g=0
    - op 4: g=0 & ASID match
    - op 5: g=0 & ASID match & VA match
    - op 6: (g | ASID match) & VA match
  - Key = latched invtlb_asid/invtlb_va. E is ignored for matching.
  - invtlb_ready and tlb_changed are asserted in the cycle of index TLB_NUM-1. tlb_changed is set only if any write occurred (sticky flag).
- Read and write in the same cycle target the same address; the compare uses pre-write data.
- Counter wrap: the scan ends at TLB_NUM-1 and never wraps.
- tlb_busy is high from the cycle after accept through the ready cycle.

Optional Feature:
TLB_FILL_LFSR_EN: when defined, the fill index is the low IDX_W bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 at reset) advanced every clk. When undefined, the fill index is the free-running counter.

Decomposition:
- Shared package: state encoding (IDLE, SRCH_SCAN, RD, WR, FILL, INV_SCAN), INVTLB op codes 0-6, PS_4M=21 / PS_4K=12 constants, ent_wsel encodings.
- Sub-module tlb_entry_match: combinational VA/ASID/global compare producing srch_hit and inv_hit for a given op.

Test Plan:
- Preload entry 5 {e=1,g=0,asid=0x3,vppn=0x12345,ps=12}, csr_asid=3, vppn=0x12345, tlbsrch pulse -> csr_srch_we with hit=1, idx=5, tlbsrch_ready 6 cycles after accept.
- Same search with csr_asid=4, g=0 -> hit=0, ready at index 15 (16 cycles).
- Entry 2 ps=21, vppn=0x12C00; search vppn=0x12DFF -> hit, idx=2.
- invtlb op=5, asid=3, va=0x12345 with entries 5 (match) and 7 (g=1) -> only entry 5 cleared, invtlb_ready + tlb_changed after 16 cycles.
- invtlb op=9 -> invtlb_ready and inv_op_err same cycle, ent_we never asserted.
- tlbfill at cycle count 37 after reset, counter mode -> ent_addr=5; rstn low during INV_SCAN at index 3 -> no ready and no further ent_we, tlb_busy=0.
